// File: rtl/syncram_sdp_be_if.sv
// Request/response bundle for syncram_sdp_be: write port, read port and result/status.
interface syncram_sdp_be_if #(
  parameter int WIDTH     = 64,
  parameter int WIDTHAD   = 9,
  parameter int BYTE_SIZE = 8
);
  localparam int NBE = WIDTH / BYTE_SIZE;

  logic               clocken0;
  logic               wren;
  logic [WIDTHAD-1:0] wraddress;
  logic [WIDTH-1:0]   data;
  logic [NBE-1:0]     byteena;
  logic               rden;
  logic [WIDTHAD-1:0] rdaddress;
  logic [WIDTH-1:0]   q;
  logic               q_valid;
  logic               init_busy;

  modport master (
    output clocken0, wren, wraddress, data, byteena, rden, rdaddress,
    input  q, q_valid, init_busy
  );

  modport slave (
    input  clocken0, wren, wraddress, data, byteena, rden, rdaddress,
    output q, q_valid, init_busy
  );
endinterface

// File: rtl/syncram_sdp_be.sv
// Simple-dual-port synchronous RAM with byte enables, selectable read latency,
// selectable read-during-write behaviour and a post-reset clear sequencer.
module syncram_sdp_be #(
  parameter int WIDTH        = 64,
  parameter int WIDTHAD      = 9,
  parameter int NUMWORDS     = 512,
  parameter int BYTE_SIZE    = 8,
  parameter int OUT_REG      = 0,
  parameter int RDW_OLD      = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic            clock0,
  input  logic            aclr0,
  syncram_sdp_be_if.slave bus
);
  localparam int NBE = WIDTH / BYTE_SIZE;
  // Array index width; the full address is still used for range checks.
  localparam int MA = (NUMWORDS > 1) ? $clog2(NUMWORDS) : 1;
  localparam logic [WIDTHAD:0]   DEPTH     = (WIDTHAD+1)'(NUMWORDS);
  localparam logic [WIDTHAD-1:0] LAST_ADDR = WIDTHAD'(NUMWORDS - 1);

  if ((WIDTH % BYTE_SIZE) != 0 || NUMWORDS < 1 || NUMWORDS > (2**WIDTHAD)) begin : g_bad_params
    $error("syncram_sdp_be: WIDTH must be a multiple of BYTE_SIZE and NUMWORDS must fit WIDTHAD");
  end

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t             state_q;
  logic [WIDTHAD-1:0] cnt_q;
  logic               init_busy_q;

  logic [WIDTH-1:0]   mem [NUMWORDS];

  logic               ready;
  logic               wr_acc;
  logic               rd_acc;
  logic               rd_in_range;
  logic               mem_we;
  logic [MA-1:0]      mem_waddr;
  logic [WIDTH-1:0]   mem_wdata;
  logic [NBE-1:0]     mem_wbe;
  logic [NBE-1:0]     merge_be_d;

  logic [WIDTH-1:0]   rd_raw_q;
  logic               rd_valid_q;
  logic               rd_zero_q;
  logic [NBE-1:0]     merge_be_q;
  logic [WIDTH-1:0]   merge_data_q;
  logic [WIDTH-1:0]   rd_word;

  genvar gi;

  assign ready       = (state_q == S_READY);
  assign wr_acc      = bus.wren & ready & bus.clocken0 & ({1'b0, bus.wraddress} < DEPTH);
  assign rd_acc      = bus.rden & ready & bus.clocken0;
  assign rd_in_range = ({1'b0, bus.rdaddress} < DEPTH);

  // Clear sequencer: walks every address once after reset, then opens the RAM to traffic.
  always_ff @(posedge clock0 or posedge aclr0) begin
    if (aclr0) begin
      state_q     <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_READY;
      init_busy_q <= (CLEAR_ON_RST != 0);
      cnt_q       <= '0;
    end else if (bus.clocken0 && state_q == S_CLEAR) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST_ADDR) begin
        state_q     <= S_READY;
        init_busy_q <= 1'b0;
      end
    end
  end

  assign bus.init_busy = init_busy_q;

  // Single write port shared by the clear sequencer and user writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.wraddress[MA-1:0];
    mem_wdata = bus.data;
    mem_wbe   = bus.byteena;
    if (state_q == S_CLEAR) begin
      mem_we    = bus.clocken0 & ~aclr0;
      mem_waddr = cnt_q[MA-1:0];
      mem_wdata = '0;
      mem_wbe   = '1;
    end else begin
      mem_we = wr_acc & ~aclr0;
    end
  end

  // Byte-lane array write.
  always_ff @(posedge clock0) begin
    if (mem_we) begin
      for (int b = 0; b < NBE; b++) begin
        if (mem_wbe[b]) mem[mem_waddr][b*BYTE_SIZE +: BYTE_SIZE] <= mem_wdata[b*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end

  // Registered array read; the array sees old data on a same-address write.
  always_ff @(posedge clock0) begin
    if (rd_acc) rd_raw_q <= mem[bus.rdaddress[MA-1:0]];
  end

  // Lanes to overwrite with the colliding write data when new-data forwarding is selected.
  always_comb begin
    merge_be_d = '0;
    if (RDW_OLD == 0 && wr_acc && bus.wraddress == bus.rdaddress) merge_be_d = bus.byteena;
  end

  // Read-side qualifiers captured alongside the raw word; zero flag makes q read 0 after reset.
  always_ff @(posedge clock0 or posedge aclr0) begin
    if (aclr0) begin
      rd_valid_q   <= 1'b0;
      rd_zero_q    <= 1'b1;
      merge_be_q   <= '0;
      merge_data_q <= '0;
    end else if (bus.clocken0) begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_zero_q    <= ~rd_in_range;
        merge_be_q   <= merge_be_d;
        merge_data_q <= bus.data;
      end
    end
  end

  for (gi = 0; gi < NBE; gi++) begin : g_lane
    assign rd_word[gi*BYTE_SIZE +: BYTE_SIZE] =
      rd_zero_q     ? '0 :
      merge_be_q[gi] ? merge_data_q[gi*BYTE_SIZE +: BYTE_SIZE] : rd_raw_q[gi*BYTE_SIZE +: BYTE_SIZE];
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [WIDTH-1:0] q_out_q;
    logic             q_valid_out_q;

    // Extra output stage; q only moves when a completed read reaches it.
    always_ff @(posedge clock0 or posedge aclr0) begin
      if (aclr0) begin
        q_out_q       <= '0;
        q_valid_out_q <= 1'b0;
      end else if (bus.clocken0) begin
        q_valid_out_q <= rd_valid_q;
        if (rd_valid_q) q_out_q <= rd_word;
      end
    end

    assign bus.q       = q_out_q;
    assign bus.q_valid = q_valid_out_q;
  end else begin : g_noreg
    assign bus.q       = rd_word;
    assign bus.q_valid = rd_valid_q;
  end
endmodule

// File: tb/tb_syncram_sdp_be.sv
// Self-checking bench: three RAM variants share one stimulus stream and are compared
// every cycle against a behavioural model, plus table vectors and directed sequences.
module tb_syncram_sdp_be;
  localparam int W  = 64;
  localparam int AD = 4;
  localparam int BS = 8;
  localparam int NB = 8;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          clken = 1'b1, wren = 1'b0, rden = 1'b0;
  logic [AD-1:0] wa = '0, ra = '0;
  logic [W-1:0]  wd = '0;
  logic [NB-1:0] be = '0;

  syncram_sdp_be_if #(.WIDTH(W), .WIDTHAD(AD), .BYTE_SIZE(BS)) if_a ();
  syncram_sdp_be_if #(.WIDTH(W), .WIDTHAD(AD), .BYTE_SIZE(BS)) if_b ();
  syncram_sdp_be_if #(.WIDTH(W), .WIDTHAD(AD), .BYTE_SIZE(BS)) if_c ();

  assign if_a.clocken0 = clken; assign if_a.wren = wren; assign if_a.wraddress = wa;
  assign if_a.data = wd; assign if_a.byteena = be; assign if_a.rden = rden; assign if_a.rdaddress = ra;
  assign if_b.clocken0 = clken; assign if_b.wren = wren; assign if_b.wraddress = wa;
  assign if_b.data = wd; assign if_b.byteena = be; assign if_b.rden = rden; assign if_b.rdaddress = ra;
  assign if_c.clocken0 = clken; assign if_c.wren = wren; assign if_c.wraddress = wa;
  assign if_c.data = wd; assign if_c.byteena = be; assign if_c.rden = rden; assign if_c.rdaddress = ra;

  // a: depth 16, latency 1, old data; b: depth 12, latency 1, new data; c: depth 16, latency 2, old data
  syncram_sdp_be #(.WIDTH(W), .WIDTHAD(AD), .NUMWORDS(16), .BYTE_SIZE(BS), .OUT_REG(0), .RDW_OLD(1),
                   .CLEAR_ON_RST(1)) dut_a (.clock0(clk), .aclr0(rst), .bus(if_a));
  syncram_sdp_be #(.WIDTH(W), .WIDTHAD(AD), .NUMWORDS(12), .BYTE_SIZE(BS), .OUT_REG(0), .RDW_OLD(0),
                   .CLEAR_ON_RST(1)) dut_b (.clock0(clk), .aclr0(rst), .bus(if_b));
  syncram_sdp_be #(.WIDTH(W), .WIDTHAD(AD), .NUMWORDS(16), .BYTE_SIZE(BS), .OUT_REG(1), .RDW_OLD(1),
                   .CLEAR_ON_RST(1)) dut_c (.clock0(clk), .aclr0(rst), .bus(if_c));

  logic [W-1:0] q_o [ND];
  logic         qv_o [ND];
  logic         busy_o [ND];
  assign q_o[0] = if_a.q; assign qv_o[0] = if_a.q_valid; assign busy_o[0] = if_a.init_busy;
  assign q_o[1] = if_b.q; assign qv_o[1] = if_b.q_valid; assign busy_o[1] = if_b.init_busy;
  assign q_o[2] = if_c.q; assign qv_o[2] = if_c.q_valid; assign busy_o[2] = if_c.init_busy;

  // Behavioural reference model
  int           nw [ND]      = '{16, 12, 16};
  int           lat [ND]     = '{1, 1, 2};
  bit           rdw_old [ND] = '{1'b1, 1'b0, 1'b1};
  logic [W-1:0] mm [ND][16];
  int           busy_left [ND];
  logic [W-1:0] eq [ND];
  bit           ev [ND];
  bit           pv [ND][2];
  logic [W-1:0] pd [ND][2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      busy_left[d] = nw[d];
      eq[d] = '0;
      ev[d] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        pv[d][k] = 1'b0;
        pd[d][k] = '0;
      end
    end
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    logic [W-1:0] r, nword;
    bit v;
    if (!clken) return;
    for (int d = 0; d < ND; d++) begin
      v = 1'b0;
      r = '0;
      if (busy_left[d] > 0) begin
        mm[d][nw[d] - busy_left[d]] = '0;
        busy_left[d]--;
      end else begin
        if (rden) begin
          v = 1'b1;
          if (int'(ra) < nw[d]) r = mm[d][ra];
        end
        if (wren && int'(wa) < nw[d]) begin
          nword = mm[d][wa];
          for (int b = 0; b < NB; b++) if (be[b]) nword[b*8 +: 8] = wd[b*8 +: 8];
          if (!rdw_old[d] && rden && ra == wa) r = nword;
          mm[d][wa] = nword;
        end
      end
      // A result emerges lat[d] enabled edges after its request.
      if (lat[d] == 2) begin
        pv[d][1] = pv[d][0];
        pd[d][1] = pd[d][0];
      end
      pv[d][0] = v;
      pd[d][0] = r;
      ev[d] = pv[d][lat[d]-1];
      if (ev[d]) eq[d] = pd[d][lat[d]-1];
    end
  endtask

  task automatic cmp_model();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("model_q[%0d]", d), q_o[d], eq[d]);
      chk($sformatf("model_qv[%0d]", d), W'(qv_o[d]), W'(ev[d]));
      chk($sformatf("model_busy[%0d]", d), W'(busy_o[d]), W'(busy_left[d] > 0));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_qv[%0d]", d), W'(qv_o[d]), '0);
      chk($sformatf("rst_q[%0d]", d), q_o[d], '0);
    end
    cmp_model();
    @(posedge clk);
    #1;
    cmp_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_in(input bit w, input int a_w, input logic [W-1:0] d_w, input logic [NB-1:0] b_w,
                        input bit r, input int a_r);
    wren = w; wa = AD'(a_w); wd = d_w; be = b_w; rden = r; ra = AD'(a_r);
  endtask

  task automatic rand_in();
    wren = 1'($urandom_range(0, 1));
    rden = 1'($urandom_range(0, 1));
    wa   = AD'($urandom_range(0, 15));
    ra   = ($urandom_range(0, 3) == 0) ? wa : AD'($urandom_range(0, 15));
    wd   = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0:       be = '0;
      1:       be = '1;
      default: be = NB'($urandom_range(0, 255));
    endcase
  endtask

  typedef struct {
    bit           wr;
    int           wa;
    logic [W-1:0] wd;
    logic [NB-1:0] be;
    bit           rd;
    int           ra;
    logic [W-1:0] exp_q;
    bit           exp_v;
  } vec_t;

  vec_t tbl [16];

  initial begin
    // Expected values below are for dut_a (depth 16, latency 1, old data on collision).
    tbl[0]  = '{1'b1, 5,  64'h1122334455667788, 8'hFF, 1'b0, 0,  64'h0, 1'b0};
    tbl[1]  = '{1'b1, 5,  64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, 0,  64'h0, 1'b0};
    tbl[2]  = '{1'b0, 0,  64'h0,                8'h00, 1'b1, 5,  64'h11223344AAAAAAAA, 1'b1};
    tbl[3]  = '{1'b1, 3,  64'h1,                8'hFF, 1'b0, 0,  64'h11223344AAAAAAAA, 1'b0};
    tbl[4]  = '{1'b1, 3,  64'h2,                8'hFF, 1'b1, 3,  64'h1, 1'b1};
    tbl[5]  = '{1'b0, 0,  64'h0,                8'h00, 1'b1, 3,  64'h2, 1'b1};
    tbl[6]  = '{1'b1, 0,  64'h000000000000BEEF, 8'h03, 1'b0, 0,  64'h2, 1'b0};
    tbl[7]  = '{1'b1, 1,  64'hDEADBEEF00000000, 8'hF0, 1'b0, 0,  64'h2, 1'b0};
    tbl[8]  = '{1'b1, 2,  64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b1, 2,  64'h0, 1'b1};
    tbl[9]  = '{1'b1, 2,  64'h0123456789ABCDEF, 8'hFF, 1'b1, 0,  64'hBEEF, 1'b1};
    tbl[10] = '{1'b0, 0,  64'h0,                8'h00, 1'b1, 1,  64'hDEADBEEF00000000, 1'b1};
    tbl[11] = '{1'b1, 15, 64'h55,               8'h01, 1'b1, 15, 64'h0, 1'b1};
    tbl[12] = '{1'b0, 0,  64'h0,                8'h00, 1'b1, 15, 64'h55, 1'b1};
    tbl[13] = '{1'b0, 0,  64'h0,                8'h00, 1'b1, 2,  64'h0123456789ABCDEF, 1'b1};
    tbl[14] = '{1'b1, 2,  64'hFFFFFFFFFFFFFFFF, 8'h81, 1'b0, 0,  64'h0123456789ABCDEF, 1'b0};
    tbl[15] = '{1'b0, 0,  64'h0,                8'h00, 1'b1, 2,  64'hFF23456789ABCDFF, 1'b1};

    for (int d = 0; d < ND; d++) for (int i = 0; i < 16; i++) mm[d][i] = '0;

    // Reset and clear sequence with junk requests that must be ignored.
    apply_reset();
    for (int k = 1; k <= 16; k++) begin
      rand_in();
      step();
      chk($sformatf("clear_busy_a[%0d]", k), W'(if_a.init_busy), W'(k < 16));
      chk($sformatf("clear_busy_b[%0d]", k), W'(if_b.init_busy), W'(k < 12));
    end
    for (int i = 0; i < 16; i++) begin
      set_in(1'b0, 0, '0, '0, 1'b1, i);
      step();
      chk($sformatf("clear_rd_q[%0d]", i), if_a.q, '0);
      chk($sformatf("clear_rd_v[%0d]", i), W'(if_a.q_valid), W'(1));
    end
    set_in(1'b0, 0, '0, '0, 1'b0, 0);
    step();

    // Table vectors.
    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].rd, tbl[i].ra);
      step();
      chk($sformatf("tbl_q[%0d]", i), if_a.q, tbl[i].exp_q);
      chk($sformatf("tbl_v[%0d]", i), W'(if_a.q_valid), W'(tbl[i].exp_v));
    end

    // Same-address read+write: old data on a, merged new data on b.
    set_in(1'b1, 3, 64'h7, 8'hFF, 1'b0, 0); step();
    set_in(1'b1, 3, 64'h9, 8'hFF, 1'b1, 3); step();
    chk("rdw_old_a", if_a.q, 64'h7);
    chk("rdw_new_b", if_b.q, 64'h9);
    chk("rdw_new_b_v", W'(if_b.q_valid), W'(1));
    set_in(1'b0, 0, '0, '0, 1'b0, 0); step();

    // Out of range on b (depth 12): addr 14 write dropped, addr 13 read gives 0.
    set_in(1'b1, 10, 64'h1234, 8'hFF, 1'b0, 0); step();
    set_in(1'b1, 14, 64'hFFFF, 8'hFF, 1'b0, 0); step();
    set_in(1'b0, 0, '0, '0, 1'b1, 10); step();
    chk("oob_alias_b", if_b.q, 64'h1234);
    set_in(1'b0, 0, '0, '0, 1'b1, 13); step();
    chk("oob_rd_b_q", if_b.q, '0);
    chk("oob_rd_b_v", W'(if_b.q_valid), W'(1));
    set_in(1'b0, 0, '0, '0, 1'b0, 0); step(); step();

    // Latency-2 ordering on c, then the same with a stall.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, i, 64'hC0 + W'(i), 8'hFF, 1'b0, 0); step();
    end
    set_in(1'b0, 0, '0, '0, 1'b0, 0); step(); step();
    for (int pass = 0; pass < 2; pass++) begin
      set_in(1'b0, 0, '0, '0, 1'b1, 0); step();
      chk($sformatf("lat2_v0[%0d]", pass), W'(if_c.q_valid), '0);
      set_in(1'b0, 0, '0, '0, 1'b1, 1); step();
      chk($sformatf("lat2_q1[%0d]", pass), if_c.q, 64'hC0);
      set_in(1'b0, 0, '0, '0, 1'b1, 2); step();
      chk($sformatf("lat2_q2[%0d]", pass), if_c.q, 64'hC1);
      set_in(1'b0, 0, '0, '0, 1'b0, 0);
      if (pass == 1) begin
        clken = 1'b0; step();
        chk("stall_q", if_c.q, 64'hC1);
        chk("stall_v", W'(if_c.q_valid), W'(1));
        clken = 1'b1;
      end
      step();
      chk($sformatf("lat2_q3[%0d]", pass), if_c.q, 64'hC2);
      chk($sformatf("lat2_v3[%0d]", pass), W'(if_c.q_valid), W'(1));
      step();
      chk($sformatf("lat2_vend[%0d]", pass), W'(if_c.q_valid), '0);
      chk($sformatf("lat2_hold[%0d]", pass), if_c.q, 64'hC2);
    end

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rand_in();
      clken = ($urandom_range(0, 9) != 0);
      step();
    end
    clken = 1'b1;

    // Reset while a read result is showing, then reset again mid-clear at count 7.
    set_in(1'b0, 0, '0, '0, 1'b1, 5); step();
    chk("pre_rst_v", W'(if_a.q_valid), W'(1));
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      rand_in();
      step();
    end
    apply_reset();
    for (int k = 0; k < 16; k++) begin
      rand_in();
      step();
    end
    for (int i = 0; i < 16; i++) begin
      set_in(1'b0, 0, '0, '0, 1'b1, i);
      step();
      chk($sformatf("reclear_q[%0d]", i), if_a.q, '0);
    end
    set_in(1'b0, 0, '0, '0, 1'b0, 0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
